// File: rtl/an_sec_pkg.sv
`default_nettype none
// ============================================================================
// an_sec_pkg : shared constants and types for the AN-code (A=83) decode scheduler
// Rev 1.0
// ============================================================================
package an_sec_pkg;

    localparam int A       = 83;
    localparam int W_BITS  = 38;
    localparam int N_BITS  = 31;
    localparam int ID_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [ID_BITS-1:0] id;
        logic [N_BITS-1:0]  n;
        logic               err;
    } rsp_t;

endpackage
`default_nettype wire

// File: rtl/an_sec_rr_arbiter.sv
`default_nettype none
// ============================================================================
// an_sec_rr_arbiter : combinational round-robin pick starting after last_grant
// Rev 1.0
// ============================================================================
module an_sec_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_BITS = 2
) (
    input  logic [NREQ-1:0]    req,
    input  logic [ID_BITS-1:0] last_grant,
    output logic [NREQ-1:0]    grant,
    output logic [ID_BITS-1:0] grant_idx,
    output logic               any
);
    import an_sec_pkg::*;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    int                start;
    int                cand;

    // Rotate so bit 0 is the requester just after last_grant, then take the lowest set bit.
    always_comb begin
        start   = (int'(last_grant) + 1) % NREQ;
        req_dbl = {req, req};
        req_rot = NREQ'(req_dbl >> start);
        any     = 1'b0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req_rot[k]) begin
                any  = 1'b1;
                cand = (start + k) % NREQ;
            end
        end
        grant     = any ? (NREQ'(1) << cand) : '0;
        grant_idx = ID_BITS'(cand);
    end

endmodule
`default_nettype wire

// File: rtl/an_sec_decode_scheduler.sv
`default_nettype none
// ============================================================================
// an_sec_decode_scheduler : shares one AN-code SEC location decoder among NREQ requesters
// Rev 1.0
// ============================================================================
module an_sec_decode_scheduler #(
    parameter int NREQ     = 4,
    parameter int ID_BITS  = 2,
    parameter int W_BITS   = 38,
    parameter int N_BITS   = 31,
    parameter int TIMEOUT  = 16,
    parameter int TO_BITS  = 5,
    parameter int CNT_BITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*W_BITS-1:0] req_w,
    output logic [NREQ-1:0]        req_ready,
    output logic                   dec_start,
    output logic [W_BITS-1:0]      dec_w,
    input  logic                   dec_found,
    input  logic [N_BITS-1:0]      dec_n,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_BITS-1:0]     rsp_id,
    output logic [N_BITS-1:0]      rsp_n,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [CNT_BITS-1:0]    err_cnt
);
    import an_sec_pkg::*;

    state_e               state_q, state_d;
    logic [ID_BITS-1:0]   last_grant_q, last_grant_d;
    logic [W_BITS-1:0]    dec_w_q, dec_w_d;
    logic                 dec_start_q, dec_start_d;
    logic                 rsp_valid_q, rsp_valid_d;
    rsp_t                 rsp_q, rsp_d;
    logic [TO_BITS-1:0]   timer_q, timer_d;
    logic [CNT_BITS-1:0]  err_cnt_q, err_cnt_d;

    logic [NREQ-1:0]      grant;
    logic [ID_BITS-1:0]   grant_idx;
    logic                 grant_any;

    an_sec_rr_arbiter #(
        .NREQ    (NREQ),
        .ID_BITS (ID_BITS)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any        (grant_any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        dec_w_d      = dec_w_q;
        dec_start_d  = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_d        = rsp_q;
        timer_d      = timer_q;
        err_cnt_d    = err_cnt_q;
        req_ready    = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    req_ready    = grant;
                    dec_w_d      = req_w[int'(grant_idx)*W_BITS +: W_BITS];
                    rsp_d.id     = grant_idx;
                    last_grant_d = grant_idx;
                    dec_start_d  = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A found pulse in the timeout cycle still counts as a clean decode.
                if (dec_found) begin
                    rsp_d.n     = dec_n;
                    rsp_d.err   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (timer_q == TO_BITS'(TIMEOUT - 1)) begin
                    rsp_d.n     = '0;
                    rsp_d.err   = 1'b1;
                    rsp_valid_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_BITS'(NREQ - 1);
            dec_w_q      <= '0;
            dec_start_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_q        <= '0;
            timer_q      <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            dec_w_q      <= dec_w_d;
            dec_start_q  <= dec_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_q        <= rsp_d;
            timer_q      <= timer_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign dec_start = dec_start_q;
    assign dec_w     = dec_w_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_q.id;
    assign rsp_n     = rsp_q.n;
    assign rsp_err   = rsp_q.err;
    assign busy      = (state_q != ST_IDLE);
    assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_an_sec_decode_scheduler.sv
`default_nettype none
// ============================================================================
// tb_an_sec_decode_scheduler : directed bench with a latency-programmable decoder model
// Rev 1.0
// ============================================================================
module tb_an_sec_decode_scheduler;

    localparam int NREQ     = 4;
    localparam int ID_BITS  = 2;
    localparam int W_BITS   = 38;
    localparam int N_BITS   = 31;
    localparam int CNT_BITS = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*W_BITS-1:0] req_w;
    logic [NREQ-1:0]        req_ready;
    logic                   dec_start;
    logic [W_BITS-1:0]      dec_w;
    logic                   dec_found;
    logic [N_BITS-1:0]      dec_n;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_BITS-1:0]     rsp_id;
    logic [N_BITS-1:0]      rsp_n;
    logic                   rsp_err;
    logic                   busy;
    logic [CNT_BITS-1:0]    err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    an_sec_decode_scheduler #(
        .NREQ(NREQ), .ID_BITS(ID_BITS), .W_BITS(W_BITS), .N_BITS(N_BITS),
        .TIMEOUT(16), .TO_BITS(5), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_w(req_w),
        .req_ready(req_ready), .dec_start(dec_start), .dec_w(dec_w),
        .dec_found(dec_found), .dec_n(dec_n), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_n(rsp_n),
        .rsp_err(rsp_err), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Decoder model: found pulses m_lat cycles after the dec_start cycle (m_lat >= 2).
    logic              m_en;
    int                m_lat;
    logic              m_found;
    logic [N_BITS-1:0] m_n;
    logic              m_pend;
    int                m_cnt;
    logic              inj_found;
    logic [N_BITS-1:0] inj_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  <= 1'b0;
            m_cnt   <= 0;
            m_found <= 1'b0;
            m_n     <= '0;
        end else begin
            m_found <= 1'b0;
            if (dec_start && m_en) begin
                m_pend <= 1'b1;
                m_cnt  <= 1;
            end else if (m_pend) begin
                if (m_cnt == m_lat - 1) begin
                    m_found <= 1'b1;
                    m_n     <= N_BITS'(dec_w / an_sec_pkg::A);
                    m_pend  <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    assign dec_found = m_found | inj_found;
    assign dec_n     = inj_found ? inj_n : m_n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int idx, input logic [W_BITS-1:0] w);
        req_w[idx*W_BITS +: W_BITS] = w;
    endtask

    // Called in an IDLE cycle with req_valid already driven; leaves the bench in the ISSUE cycle.
    task automatic accept(input string tag, input int exp_idx);
        #1;
        chk({tag, "_ready"}, req_ready, 64'(1) << exp_idx);
        tick();
    endtask

    // Called in the ISSUE cycle; accept-to-rsp_valid latency is counted from the accept cycle.
    task automatic collect(input string tag, input int exp_id, input logic [N_BITS-1:0] exp_n,
                           input logic exp_err, input logic [W_BITS-1:0] exp_w, input int exp_lat);
        int lat    = 1;
        int starts = 0;
        bit stable = 1'b1;
        bit quiet  = 1'b1;
        while (!rsp_valid && lat < 40) begin
            if (dec_w !== exp_w) stable = 1'b0;
            if (req_ready !== '0) quiet = 1'b0;
            if (dec_start === 1'b1) starts++;
            tick();
            lat++;
        end
        chk({tag, "_rspvalid"}, rsp_valid, 1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_start_pulses"}, starts, 1);
        chk({tag, "_decw_held"}, stable, 1);
        chk({tag, "_noready_busy"}, quiet, 1);
        chk({tag, "_id"}, rsp_id, exp_id);
        chk({tag, "_n"}, rsp_n, exp_n);
        chk({tag, "_err"}, rsp_err, exp_err);
        chk({tag, "_ready_in_resp"}, req_ready, 0);
        if (rsp_ready) tick();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_order[5] = '{0, 1, 2, 3, 0};
        int hs;
        int mid_cnt;
        logic [N_BITS-1:0] s_n;
        logic [ID_BITS-1:0] s_id;
        bit bp_ok;

        req_valid = '0; req_w = '0; rsp_ready = 1'b1;
        m_en = 1'b1; m_lat = 4; inj_found = 1'b0; inj_n = '0;
        for (int i = 0; i < NREQ; i++) set_w(i, W_BITS'(83 * (100 + i)));

        // Reset values
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_dec_w", dec_w, 0);
        chk("rst_dec_start", dec_start, 0);
        chk("rst_rsp_n", rsp_n, 0);
        chk("rst_req_ready", req_ready, 0);
        rst_n = 1'b1;
        tick();

        // Single clean request
        set_w(0, W_BITS'(830));
        req_valid = 4'b0001;
        accept("t1", 0);
        req_valid = '0;
        chk("t1_dec_start", dec_start, 1);
        collect("t1", 0, 10, 1'b0, W_BITS'(830), 6);
        chk("t1_idle", busy, 0);

        // Corrected single error, residue 4
        set_w(2, W_BITS'(83004));
        req_valid = 4'b0100;
        accept("t2", 2);
        req_valid = '0;
        collect("t2", 2, 1000, 1'b0, W_BITS'(83004), 6);
        set_w(0, W_BITS'(8300));
        set_w(2, W_BITS'(8466));

        // Round-robin from a fresh reset
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            accept("rr", rr_order[g]);
            collect("rr", rr_order[g], N_BITS'(100 + rr_order[g]), 1'b0,
                    W_BITS'(83 * (100 + rr_order[g])), 6);
        end
        req_valid = 4'b1001;
        accept("lr_a", 3);
        collect("lr_a", 3, 103, 1'b0, W_BITS'(83 * 103), 6);
        accept("lr_b", 0);
        req_valid = 4'b1011;
        collect("lr_b", 0, 100, 1'b0, W_BITS'(8300), 6);
        accept("lr_c", 1);
        collect("lr_c", 1, 101, 1'b0, W_BITS'(83 * 101), 6);
        accept("lr_d", 3);
        req_valid = '0;
        collect("lr_d", 3, 103, 1'b0, W_BITS'(83 * 103), 6);

        // Timeout, then a late found and backpressure while holding the response
        m_en = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        accept("to", 0);
        req_valid = '0;
        collect("to", 0, 0, 1'b1, W_BITS'(8300), 18);
        chk("to_err_cnt", err_cnt, 1);
        inj_found = 1'b1; inj_n = N_BITS'(77);
        tick();
        inj_found = 1'b0;
        chk("late_found_n", rsp_n, 0);
        chk("late_found_err", rsp_err, 1);
        chk("late_found_cnt", err_cnt, 1);
        req_valid = 4'b1111;
        s_n = rsp_n; s_id = rsp_id;
        bp_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid !== 1'b1 || rsp_n !== s_n || rsp_id !== s_id ||
                rsp_err !== 1'b1 || req_ready !== '0) bp_ok = 1'b0;
            tick();
        end
        chk("bp_stable", bp_ok, 1);
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        chk("bp_released", rsp_valid, 0);

        // Found in the same cycle the timer reaches TIMEOUT-1
        m_en = 1'b1; m_lat = 16;
        req_valid = 4'b0010;
        accept("sim", 1);
        req_valid = '0;
        collect("sim", 1, 101, 1'b0, W_BITS'(83 * 101), 18);
        chk("sim_err_cnt", err_cnt, 1);

        // 255 further timeouts saturate the counter
        m_en = 1'b0;
        req_valid = 4'b0001;
        hs = 0; mid_cnt = -1;
        for (int c = 0; c < 255 * 25 && hs < 255; c++) begin
            tick();
            if (rsp_valid) begin
                hs++;
                if (hs == 100) mid_cnt = int'(err_cnt);
            end
        end
        req_valid = '0;
        chk("sat_handshakes", hs, 255);
        chk("sat_mid_cnt", mid_cnt, 101);
        chk("sat_final_cnt", err_cnt, 255);
        tick();

        // Reset in the middle of WAIT
        m_en = 1'b1; m_lat = 4;
        req_valid = 4'b0100;
        accept("rw", 2);
        req_valid = '0;
        tick(); tick();
        chk("rw_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_dec_w", dec_w, 0);
        chk("rw_rsp_valid", rsp_valid, 0);
        chk("rw_err_cnt", err_cnt, 0);
        chk("rw_rsp_n", rsp_n, 0);
        tick(); tick();
        chk("rw_no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        accept("rw_first", 0);
        req_valid = '0;
        collect("rw_first", 0, 100, 1'b0, W_BITS'(8300), 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
